// File: rtl/acc_bank.sv
// Output accumulator bank: captures per-column bottom-row psums into an N x N buffer (overwrite or accumulate), then drains C row by row.
// Latency: tile completes one cycle after the final column write; the first row is valid the cycle after that, then one row per cycle.
// Backpressure: out_valid_o/out_ready_i stream; row data is held stable while stalled. Optional saturation via macro ACC_BANK_SAT_EN.
module acc_bank #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tile_start_i,
  input  logic                 tile_first_i,
  input  logic                 tile_last_i,
  input  logic [N-1:0][DW-1:0] psum_i,
  input  logic [N-1:0]         acc_valid_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [N-1:0][AW-1:0] out_data_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 sat_o
);

  localparam int PW = $clog2(N + 1);
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PFULL = PW'(N);
  localparam logic [RW-1:0] RLAST = RW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] mem [N][N];
  logic [PW-1:0] wptr [N];
  logic [RW-1:0] rptr;
  logic          first_q, last_q;
  logic          err_q;

  logic [AW-1:0] ext [N];
  logic [AW-1:0] cur [N];
  logic [AW-1:0] nxt [N];
  logic [N-1:0]  wr_en;
  logic [N-1:0]  ovf;
  logic          all_full;
  logic          fill_done;
  logic          xfer;
  logic          last_row;
  logic          err_set;

`ifdef ACC_BANK_SAT_EN
  logic [AW:0]   sum_w;
  logic [N-1:0]  sat_hit;
  logic          sat_q;
`endif

  assign fill_done = (state == S_FILL) && all_full;
  assign xfer      = out_valid_o && out_ready_i;
  assign last_row  = (rptr == RLAST);

  // Per-column write decode and overwrite/accumulate datapath.
  always_comb begin
    all_full = 1'b1;
`ifdef ACC_BANK_SAT_EN
    sum_w   = '0;
    sat_hit = '0;
`endif
    for (int j = 0; j < N; j++) begin
      wr_en[j] = (state == S_FILL) && acc_valid_i[j] && (wptr[j] != PFULL);
      ovf[j]   = (state == S_FILL) && acc_valid_i[j] && (wptr[j] == PFULL);
      if (wptr[j] != PFULL) all_full = 1'b0;
      ext[j] = AW'($signed(psum_i[j]));
      // Index truncation only matters when the column is full, and then no write happens.
      cur[j] = mem[wptr[j][RW-1:0]][j];
`ifdef ACC_BANK_SAT_EN
      sum_w = {cur[j][AW-1], cur[j]} + {ext[j][AW-1], ext[j]};
      if (sum_w[AW] != sum_w[AW-1]) begin
        sat_hit[j] = wr_en[j] && !first_q;
        nxt[j]     = sum_w[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end else begin
        nxt[j] = sum_w[AW-1:0];
      end
`else
      nxt[j] = cur[j] + ext[j];
`endif
      if (first_q) nxt[j] = ext[j];
    end
  end

  // Protocol violations: strobes outside FILL, overflowing strobes, tile_start while busy.
  always_comb begin
    err_set = 1'b0;
    case (state)
      S_IDLE:  err_set = |acc_valid_i;
      S_FILL:  err_set = tile_start_i || (|ovf);
      S_DRAIN: err_set = tile_start_i || (|acc_valid_i);
      default: err_set = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (tile_start_i) state_nxt = S_FILL;
      S_FILL:  if (all_full) state_nxt = last_q ? S_DRAIN : S_IDLE;
      S_DRAIN: if (xfer && last_row) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Tile flags, column write pointers, drain pointer and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_q <= 1'b0;
      last_q  <= 1'b0;
      rptr    <= '0;
      err_q   <= 1'b0;
      for (int j = 0; j < N; j++) wptr[j] <= '0;
    end else begin
      if (state == S_IDLE && tile_start_i) begin
        first_q <= tile_first_i;
        last_q  <= tile_last_i;
        for (int j = 0; j < N; j++) wptr[j] <= '0;
      end
      for (int j = 0; j < N; j++) begin
        if (wr_en[j]) wptr[j] <= wptr[j] + PW'(1);
      end
      if (fill_done)  rptr <= '0;
      else if (xfer)  rptr <= last_row ? '0 : rptr + RW'(1);
      if (err_set)    err_q <= 1'b1;
    end
  end

  // Result buffer; contents persist across idle and drain, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (wr_en[j]) mem[wptr[j][RW-1:0]][j] <= nxt[j];
      end
    end
  end

`ifdef ACC_BANK_SAT_EN
  // Sticky saturation flag, set by any clamped accumulate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        sat_q <= 1'b0;
    else if (|sat_hit)  sat_q <= 1'b1;
  end
  assign sat_o = sat_q;
`else
  assign sat_o = 1'b0;
`endif

  // Drain presentation straight from registered storage; zero outside DRAIN.
  always_comb begin
    out_data_o = '0;
    if (state == S_DRAIN) begin
      for (int j = 0; j < N; j++) out_data_o[j] = mem[rptr][j];
    end
  end

  assign out_valid_o = (state == S_DRAIN);
  assign out_last_o  = (state == S_DRAIN) && last_row;
  assign busy_o      = (state != S_IDLE);
  assign err_o       = err_q;

endmodule

// File: doc/acc_bank.md
Name: acc_bank

Overview:
- Output accumulator bank directly downstream of the systolic array and its controller.
- Each column captures the bottom-row partial sums of the array, gated by that column's accumulator-valid strobe from the controller.
- Per tile, the bank either overwrites or adds into an N x N result buffer, so K-dimension tiles can be summed.
- After the last tile it drains the result matrix C one row per cycle over a valid/ready stream.

Parameters:
- N, 4, array dimension (columns, and rows of C held).
- DW, 16, signed partial-sum width from the array.
- AW, 32, signed accumulator width (AW >= DW).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- tile_start_i  in  1  pulse; starts capture of one tile.
- tile_first_i  in  1  sampled with tile_start_i; 1 = overwrite buffer, 0 = accumulate.
- tile_last_i  in  1  sampled with tile_start_i; 1 = drain after this tile.
- psum_i  in  [N] x DW  signed bottom-row partial sums, one per column.
- acc_valid_i  in  [N] x 1  per-column capture strobe from controller.
- out_valid_o  out  1  result row valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  [N] x AW  result row; element j = C[row][j].
- out_last_o  out  1  marks final row (row N-1).
- busy_o  out  1  high in S_FILL or S_DRAIN.
- err_o  out  1  sticky protocol error.
- sat_o  out  1  sticky saturation flag (see Optional Feature).

Behaviour:
- Reset (async, rst_ni low):
  - state = S_IDLE; all outputs 0.
  - Buffer mem[N][N], per-column write pointers wptr[j], read pointer rptr, and latched first/last flags all cleared.
  - Reset mid-FILL or mid-DRAIN aborts immediately; no partial row is presented after release.
- States: S_IDLE, S_FILL, S_DRAIN.
- S_IDLE:
  - tile_start_i=1 -> latch tile_first_i/tile_last_i, clear all wptr, go S_FILL next cycle.
  - Any acc_valid_i bit high -> err_o set, data ignored.
- S_FILL:
  - Columns are independent. acc_valid_i[j]=1 with wptr[j]<N:
    - first: mem[wptr[j]][j] <= sext(psum_i[j]).
    - otherwise: mem[wptr[j]][j] <= mem[wptr[j]][j] + sext(psum_i[j]).
    - Then wptr[j]++.
  - acc_valid_i[j]=1 with wptr[j]==N -> ignored, err_o set.
  - Tile complete on the cycle every wptr[j]==N, evaluated on registered pointers, so one cycle after the final write.
    - last latched -> S_DRAIN with rptr=0.
    - otherwise -> S_IDLE.
  - tile_start_i in S_FILL is ignored and sets err_o.
- S_DRAIN:
  - out_valid_o=1; out_data_o = mem[rptr] (registered storage, stable while stalled); out_last_o = (rptr==N-1).
  - Transfer = out_valid_o & out_ready_i -> rptr++.
  - Transfer with rptr==N-1 -> S_IDLE next cycle, out_valid_o low that cycle.
  - tile_start_i and acc_valid_i in S_DRAIN are ignored and set err_o.
  - First row is valid one cycle after tile completion. With out_ready_i held high, N rows stream on N consecutive cycles.
- Arithmetic:
  - sext extends psum_i to AW bits.
  - Default addition is AW-bit two's complement wrap.
- Buffer contents persist through S_IDLE between tiles and after drain; only a first tile or reset clears them.
- err_o and sat_o clear only on reset.

Optional Feature:
- Macro ACC_BANK_SAT_EN.
- Defined:
  - Accumulate adds saturate to [-2^(AW-1), 2^(AW-1)-1].
  - Any saturating add sets sat_o, which is sticky.
- Undefined:
  - Adds wrap modulo 2^AW.
  - sat_o is tied 0.

Test Plan:
- N=4, single tile first=1 last=1; column j receives psums 10*j+r for r=0..3, with column j strobes skewed j cycles; ready=1 -> 4 rows on consecutive cycles, row r = {r, 10+r, 20+r, 30+r}, out_last_o only on row 3, then busy_o=0.
- Two tiles: tile 1 (first=1, last=0) all psums 5; tile 2 (first=0, last=1) all psums -2 -> every out_data_o element = 3; no output after tile 1.
- Drain backpressure: out_ready_i toggled 1,0,0,1,1,0,1 -> each row held stable while stalled; exactly 4 transfers in order; out_last_o held with row 3 until accepted.
- Protocol errors: acc_valid_i[0] in S_IDLE, or a fifth strobe on column 2 in S_FILL -> err_o=1, buffer contents unchanged, normal completion still occurs.
- Reset during S_DRAIN after row 1 accepted -> out_valid_o=0 immediately (asynchronously); after release, state S_IDLE, busy_o=0, all buffer entries 0.
- AW=16, accumulate 32767 + 1: with ACC_BANK_SAT_EN -> 32767 and sat_o=1; without -> -32768 and sat_o=0.
